// File: rtl/ibex_x_compressed_issue.sv
// ibex_x_compressed_issue: routes fetched instructions to the decoder, offloading
// compressed instructions the core rejects to a coprocessor over the X-IF compressed interface.
package ibex_pkg;
  parameter int unsigned X_ID_WIDTH = 4;
  typedef struct packed {
    logic [15:0]           instr;
    logic [1:0]            mode;
    logic [X_ID_WIDTH-1:0] id;
  } x_compressed_req_t;
  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;
endpackage

module ibex_x_compressed_issue
  import ibex_pkg::*;
#(
  parameter int unsigned XIdWidth = X_ID_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [1:0]         priv_mode_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [31:0]        fetch_instr_i,
  input  logic [31:0]        fetch_instr_dec_i,
  input  logic               fetch_illegal_c_i,
  output logic               x_compressed_valid_o,
  input  logic               x_compressed_ready_i,
  output x_compressed_req_t  x_compressed_req_o,
  input  x_compressed_resp_t x_compressed_resp_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_instr_o,
  output logic               out_illegal_o,
  output logic               out_offloaded_o
);
  typedef enum logic [1:0] {IDLE, REQ, OUT} state_e;
  state_e              state_q;
  x_compressed_req_t   req_q;
  logic [XIdWidth-1:0] id_q;
  logic                flush_pend_q;
  logic [31:0]         out_instr_q;
  logic                out_illegal_q;
  logic                out_offl_q;
  logic                fetch_hs;
  logic                is_c;
  assign fetch_ready_o        = !flush_i && (state_q == IDLE || (state_q == OUT && out_ready_i));
  assign fetch_hs             = fetch_valid_i && fetch_ready_o;
  assign is_c                 = fetch_instr_i[1:0] != 2'b11;
  assign x_compressed_valid_o = state_q == REQ;
  assign x_compressed_req_o   = req_q;
  assign out_valid_o          = state_q == OUT;
  assign out_instr_o          = out_instr_q;
  assign out_illegal_o        = out_illegal_q;
  assign out_offloaded_o      = out_offl_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      req_q         <= '0;
      id_q          <= '0;
      flush_pend_q  <= 1'b0;
      out_instr_q   <= '0;
      out_illegal_q <= 1'b0;
      out_offl_q    <= 1'b0;
    end else if (state_q == REQ) begin
      // The request stays up until the handshake; a flush only marks the answer as stale.
      if (x_compressed_ready_i) begin
        id_q         <= id_q + 1'b1;
        flush_pend_q <= 1'b0;
        if (flush_pend_q || flush_i) begin
          state_q <= IDLE;
        end else begin
          state_q       <= OUT;
          out_instr_q   <= x_compressed_resp_i.accept ? x_compressed_resp_i.instr : {16'b0, req_q.instr};
          out_illegal_q <= !x_compressed_resp_i.accept;
          out_offl_q    <= 1'b1;
        end
      end else if (flush_i) begin
        flush_pend_q <= 1'b1;
      end
    end else if (fetch_hs) begin
      if (is_c && fetch_illegal_c_i) begin
        state_q <= REQ;
        req_q   <= '{instr: fetch_instr_i[15:0], mode: priv_mode_i, id: id_q};
      end else begin
        state_q       <= OUT;
        out_instr_q   <= is_c ? fetch_instr_dec_i : fetch_instr_i;
        out_illegal_q <= 1'b0;
        out_offl_q    <= 1'b0;
      end
    end else if (flush_i || out_ready_i) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ibex_x_compressed_issue.sv
// tb_ibex_x_compressed_issue: directed and random stimulus checked by a queue-based scoreboard.
module tb_ibex_x_compressed_issue;
  import ibex_pkg::*;
  localparam int NID = 1 << X_ID_WIDTH;
  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic        off;
  } res_t;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush, fetch_valid, fetch_ready, fetch_ill, x_valid, x_ready;
  logic               out_valid, out_ready, out_illegal, out_offl;
  logic [1:0]         mode;
  logic [31:0]        fetch_instr, fetch_dec, out_instr;
  x_compressed_req_t  x_req;
  x_compressed_resp_t x_resp;
  int                 n_chk = 0;
  int                 n_fail = 0;
  res_t               q_out[$];
  x_compressed_req_t  q_req[$];
  bit                 pend = 0;
  int                 m_id = 0;

  always #5 clk = ~clk;

  ibex_x_compressed_issue dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .priv_mode_i         (mode),
    .fetch_valid_i       (fetch_valid),
    .fetch_ready_o       (fetch_ready),
    .fetch_instr_i       (fetch_instr),
    .fetch_instr_dec_i   (fetch_dec),
    .fetch_illegal_c_i   (fetch_ill),
    .x_compressed_valid_o(x_valid),
    .x_compressed_ready_i(x_ready),
    .x_compressed_req_o  (x_req),
    .x_compressed_resp_i (x_resp),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_instr_o         (out_instr),
    .out_illegal_o       (out_illegal),
    .out_offloaded_o     (out_offl)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare what the DUT shows now, then advance the model by the
  // transfers that the current inputs cause at the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_out.delete();
      q_req.delete();
      pend = 0;
      m_id = 0;
    end else begin
      automatic bit exp_rdy = !flush && q_req.size() == 0 && (q_out.size() == 0 || out_ready);
      check("fetch_ready", 64'(fetch_ready), 64'(exp_rdy));
      check("x_valid", 64'(x_valid), 64'(q_req.size() != 0));
      if (q_req.size() != 0) check("x_req", 64'(x_req), 64'(q_req[0]));
      check("out_valid", 64'(out_valid), 64'(q_out.size() != 0));
      if (q_out.size() != 0) begin
        check("out_instr", 64'(out_instr), 64'(q_out[0].instr));
        check("out_illegal", 64'(out_illegal), 64'(q_out[0].ill));
        check("out_offloaded", 64'(out_offl), 64'(q_out[0].off));
        if (flush || out_ready) void'(q_out.pop_front());
      end
      if (q_req.size() != 0) begin
        if (x_ready) begin
          automatic x_compressed_req_t r = q_req.pop_front();
          m_id = (m_id + 1) % NID;
          if (pend || flush) pend = 0;
          else if (x_resp.accept) q_out.push_back('{instr: x_resp.instr, ill: 1'b0, off: 1'b1});
          else q_out.push_back('{instr: {16'b0, r.instr}, ill: 1'b1, off: 1'b1});
        end else if (flush) begin
          pend = 1;
        end
      end else if (fetch_valid && exp_rdy) begin
        if (fetch_instr[1:0] == 2'b11) q_out.push_back('{instr: fetch_instr, ill: 1'b0, off: 1'b0});
        else if (!fetch_ill) q_out.push_back('{instr: fetch_dec, ill: 1'b0, off: 1'b0});
        else q_req.push_back('{instr: fetch_instr[15:0], mode: mode, id: X_ID_WIDTH'(m_id)});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 0;
    mode        = 0;
    fetch_valid = 0;
    fetch_instr = 0;
    fetch_dec   = 0;
    fetch_ill   = 0;
    x_ready     = 0;
    x_resp      = '0;
    out_ready   = 1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] dec, input logic ill, input logic [1:0] m);
    fetch_valid = 1;
    fetch_instr = instr;
    fetch_dec   = dec;
    fetch_ill   = ill;
    mode        = m;
  endtask

  task automatic offload(input logic [31:0] instr, input logic accept, input int wait_cycles);
    fetch(instr, 32'h0, 1'b1, 2'b11);
    x_ready = 0;
    cyc();
    fetch_valid = 0;
    repeat (wait_cycles) cyc();
    x_ready = 1;
    x_resp  = '{instr: 32'h00108093, accept: accept};
    cyc();
    x_ready = 0;
    repeat (2) cyc();
  endtask

  initial begin
    idle();
    repeat (2) cyc();
    check("rst_x_valid", 64'(x_valid), 64'd0);
    check("rst_x_req", 64'(x_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    rst_n = 1;
    cyc();
    // pass-through, back to back
    fetch(32'h00108093, 32'h0, 1'b0, 2'b00);
    cyc();
    fetch(32'h00004505, 32'h00100513, 1'b0, 2'b00);
    cyc();
    idle();
    repeat (2) cyc();
    // offload accepted, then rejected (next id)
    offload(32'h00000085, 1'b1, 3);
    offload(32'h00000085, 1'b0, 3);
    // flush while waiting for the coprocessor
    fetch(32'h00000085, 32'h0, 1'b1, 2'b11);
    cyc();
    fetch_valid = 0;
    cyc();
    flush = 1;
    cyc();
    flush = 0;
    cyc();
    x_ready = 1;
    x_resp  = '{instr: 32'hdeadbeef, accept: 1'b1};
    cyc();
    idle();
    repeat (2) cyc();
    // output backpressure with a waiting fetch
    out_ready = 0;
    fetch(32'h00208113, 32'h0, 1'b0, 2'b00);
    cyc();
    fetch(32'h00308193, 32'h0, 1'b0, 2'b00);
    repeat (4) cyc();
    out_ready = 1;
    cyc();
    idle();
    repeat (2) cyc();
    // id wrap
    for (int i = 0; i < NID + 1; i++) offload(32'((i << 2) | 1), 1'($urandom_range(0, 1)), 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      automatic logic [31:0] w = $urandom();
      automatic int kind = $urandom_range(0, 2);
      fetch_valid = $urandom_range(0, 3) != 0;
      fetch_instr = {w[31:2], kind == 0 ? 2'b11 : 2'($urandom_range(0, 2))};
      fetch_ill   = kind == 2;
      fetch_dec   = $urandom();
      mode        = 2'($urandom_range(0, 3));
      flush       = $urandom_range(0, 15) == 0;
      x_ready     = $urandom_range(0, 1);
      x_resp      = '{instr: $urandom(), accept: 1'($urandom_range(0, 1))};
      out_ready   = $urandom_range(0, 3) != 0;
      cyc();
    end
    idle();
    repeat (3) cyc();
    // asynchronous reset while a request is outstanding
    fetch(32'h00000085, 32'h0, 1'b1, 2'b11);
    cyc();
    fetch_valid = 0;
    repeat (2) cyc();
    check("pre_rst_x_valid", 64'(x_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    check("arst_x_valid", 64'(x_valid), 64'd0);
    check("arst_x_req", 64'(x_req), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_instr", 64'(out_instr), 64'd0);
    check("arst_out_flags", 64'({out_illegal, out_offl}), 64'd0);
    cyc();
    rst_n = 1;
    cyc();
    offload(32'h00000085, 1'b1, 1);
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
